// File: rtl/logic_sweep_ctrl_pkg.sv
// Shared definitions for the switch-logic sweep sequencer.
//   state_t : controller states, encoded as seen on the 'state' port
//   VEC_W   : width of the vector driven to the function block
//   FN_W    : width of the function block response
//   CNT_W   : width of each ones-counter (holds 0..256)
package logic_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned VEC_W = 8;
    localparam int unsigned FN_W  = 3;
    localparam int unsigned CNT_W = 9;

endpackage

// File: rtl/logic_sweep_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and
// rising-edge detector.
//   clk     : board clock
//   rst     : synchronous active-high reset (level returns to released)
//   btn_raw : asynchronous, bouncy button input
//   press   : one-cycle pulse when the debounced level rises
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    import logic_sweep_ctrl_pkg::*;

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with the
    // accepted level; the level flips on the DB_CYCLES-th such sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == DB_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sequencer for the combinational switch-logic function blocks.
//   clk, rst            : board clock, synchronous active-high reset
//   sw                  : slide switches, vector source in MANUAL
//   btn_mode, btn_step  : raw buttons (mode cycle, single step)
//   f_in                : function block response to vec
//   vec                 : registered vector to the function block
//   state               : MANUAL=0, RUN=1, PAUSE=2, DONE=3
//   cnt0..cnt2          : ones-count of f_in[0..2] over the sweep
//   done                : one-cycle pulse when a sweep completes
module logic_sweep_ctrl #(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_mode,
    input  logic       btn_step,
    input  logic [2:0] f_in,
    output logic [7:0] vec,
    output logic [1:0] state,
    output logic [8:0] cnt0,
    output logic [8:0] cnt1,
    output logic [8:0] cnt2,
    output logic       done
);
    import logic_sweep_ctrl_pkg::*;

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic          mode_p;
    logic          step_p;
    state_t        st;
    state_t        st_nxt;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          adv;
    logic          last;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_mode),
        .press   (mode_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .press   (step_p)
    );

    assign state = st;

    always_comb begin
        tick   = (st == RUN) && (tick_cnt == TICK_LAST);
        // A step in PAUSE is dropped when a mode press arrives alongside it.
        adv    = tick || ((st == PAUSE) && step_p && !mode_p);
        last   = (vec == '1);
        st_nxt = st;
        case (st)
            MANUAL: if (mode_p) st_nxt = RUN;
            RUN:    if (mode_p) st_nxt = PAUSE;
            PAUSE:  if (mode_p) st_nxt = RUN;
            DONE:   if (mode_p) st_nxt = MANUAL;
            default: st_nxt = MANUAL;
        endcase
        // Completing the last vector overrides a concurrent mode press.
        if (adv && last) st_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= MANUAL;
            vec      <= '0;
            cnt0     <= '0;
            cnt1     <= '0;
            cnt2     <= '0;
            done     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            st   <= st_nxt;
            done <= (st_nxt == DONE) && (st != DONE);
            case (st)
                MANUAL: begin
                    tick_cnt <= '0;
                    if (mode_p) begin
                        vec  <= '0;
                        cnt0 <= '0;
                        cnt1 <= '0;
                        cnt2 <= '0;
                    end else begin
                        vec <= sw;
                    end
                end
                RUN: tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                default: ;
            endcase
            if (adv) begin
                cnt0 <= cnt0 + {{(CNT_W-1){1'b0}}, f_in[0]};
                cnt1 <= cnt1 + {{(CNT_W-1){1'b0}}, f_in[1]};
                cnt2 <= cnt2 + {{(CNT_W-1){1'b0}}, f_in[2]};
                if (!last) vec <= vec + VEC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Self-checking bench for logic_sweep_ctrl (TICK_DIV=4, DB_CYCLES=3).
// A cycle model predicts every output; directed scenarios add literal checks.
module tb_logic_sweep_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       btn_mode;
    logic       btn_step;
    logic [2:0] f_in;
    logic [7:0] vec;
    logic [1:0] state;
    logic [8:0] cnt0, cnt1, cnt2;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic_sweep_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn_mode (btn_mode),
        .btn_step (btn_step),
        .f_in     (f_in),
        .vec      (vec),
        .state    (state),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] fm(input logic [7:0] v);
        return {v == 8'hFF, v[1] & v[2] & v[3], v[0] ^ v[1]};
    endfunction

    assign f_in = fm(vec);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_st;
    logic [7:0] m_vec;
    int         m_c0, m_c1, m_c2;
    bit         m_done;
    int         m_tc;
    bit         m_h1[2], m_h2[2], m_lvl[2], m_p[2];
    int         m_run[2];

    task automatic model_step();
        bit raw[2];
        bit pm, ps, adv, d;
        int old;
        logic [2:0] f;
        raw[0] = btn_mode;
        raw[1] = btn_step;
        if (rst) begin
            m_st = 0; m_vec = 0; m_c0 = 0; m_c1 = 0; m_c2 = 0;
            m_done = 0; m_tc = 0;
            for (int b = 0; b < 2; b++) begin
                m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_p[b] = 0; m_run[b] = 0;
            end
        end else begin
            pm = m_p[0];
            ps = m_p[1];
            adv = 0;
            old = m_st;
            case (m_st)
                0: if (pm) begin
                       m_st = 1; m_vec = 0; m_c0 = 0; m_c1 = 0; m_c2 = 0; m_tc = 0;
                   end else m_vec = sw;
                1: begin
                       if (m_tc == TD - 1) begin adv = 1; m_tc = 0; end
                       else m_tc++;
                       if (pm) m_st = 2;
                   end
                2: if (pm) m_st = 1; else if (ps) adv = 1;
                default: if (pm) m_st = 0;
            endcase
            if (adv) begin
                f = fm(m_vec);
                m_c0 += f[0]; m_c1 += f[1]; m_c2 += f[2];
                if (m_vec == 8'hFF) m_st = 3;
                else m_vec = m_vec + 8'd1;
            end
            m_done = (m_st == 3) && (old != 3);
            // Button seen two edges late; accepted after DB disagreeing samples.
            for (int b = 0; b < 2; b++) begin
                d = m_h2[b];
                m_h2[b] = m_h1[b];
                m_h1[b] = raw[b];
                m_p[b] = 0;
                if (d != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = d; m_run[b] = 0; m_p[b] = d;
                    end
                end else m_run[b] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_state", state, m_st);
            chk("m_vec",   vec,   m_vec);
            chk("m_cnt0",  cnt0,  m_c0);
            chk("m_cnt1",  cnt1,  m_c1);
            chk("m_cnt2",  cnt2,  m_c2);
            chk("m_done",  done,  m_done);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press_btn(input bit m, input bit s);
        @(negedge clk);
        btn_mode = m; btn_step = s;
        repeat (DB + 4) @(negedge clk);
        btn_mode = 0; btn_step = 0;
        repeat (DB + 4) @(negedge clk);
    endtask

    // sel: 0 state, 1 vec, 2 done. Returns at the negedge where it matches.
    task automatic wait_sig(input int sel, input logic [7:0] val, input int budget, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = (state == val[1:0]);
                1: hit = (vec == val);
                default: hit = (done == val[0]);
            endcase
        end
        chk(name, hit, 1);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_cnt0"}, cnt0, 128);
        chk({tag, "_cnt1"}, cnt1, 32);
        chk({tag, "_cnt2"}, cnt2, 1);
        chk({tag, "_vec"},  vec,  8'hFF);
        chk({tag, "_state"}, state, 3);
    endtask

    initial begin
        int n;
        logic [7:0] held;
        rst = 1; sw = 0; btn_mode = 0; btn_step = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("rst_state", state, 0);
        chk("rst_vec", vec, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_done", done, 0);

        // Manual follow and ignored step
        sw = 8'hA5;
        @(negedge clk);
        chk("man_vec", vec, 8'hA5);
        press_btn(0, 1);
        chk("man_step_ign", state, 0);

        // Full sweep, timing from RUN entry to done
        @(negedge clk);
        btn_mode = 1;
        wait_sig(0, 8'd1, 20, "run_entry");
        n = 0;
        while (done !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_cycles", n, 1024);
        chk_counts("sweep");
        btn_mode = 0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        repeat (DB + 4) @(negedge clk);

        // DONE -> MANUAL keeps counts
        press_btn(1, 0);
        chk("man_state", state, 0);
        chk("man_keep_cnt0", cnt0, 128);

        // Pause at vec=10, hold, five steps, resume to completion
        press_btn(1, 0);
        wait_sig(1, 8'd9, 200, "reach_9");
        btn_mode = 1;
        repeat (DB + 4) @(negedge clk);
        btn_mode = 0;
        chk("pause_state", state, 2);
        repeat (110) @(negedge clk);
        chk("pause_hold_vec", vec, 8'd10);
        for (int k = 0; k < 5; k++) press_btn(0, 1);
        chk("steps_vec", vec, 8'd15);
        press_btn(1, 0);
        chk("resume_state", state, 1);
        wait_sig(2, 8'd1, 1200, "resume_done");
        chk_counts("resume");
        repeat (2) @(negedge clk);
        press_btn(1, 0);

        // Bounce: toggling then held gives one press; 2-cycle glitch gives none
        for (int k = 0; k < 10; k++) begin
            btn_mode = (k % 2 == 0);
            @(negedge clk);
        end
        btn_mode = 1;
        repeat (12) @(negedge clk);
        chk("bounce_one_press", state, 1);
        btn_mode = 0;
        repeat (DB + 4) @(negedge clk);
        btn_mode = 1;
        repeat (2) @(negedge clk);
        btn_mode = 0;
        repeat (DB + 5) @(negedge clk);
        chk("glitch_no_press", state, 1);

        // Simultaneous presses in PAUSE: mode wins
        press_btn(1, 0);
        chk("pause2_state", state, 2);
        held = vec;
        btn_mode = 1; btn_step = 1;
        wait_sig(0, 8'd1, 20, "simul_run");
        chk("simul_vec", vec, held);
        btn_mode = 0; btn_step = 0;

        // Reset mid-sweep, then a fresh sweep
        wait_sig(1, 8'd100, 2000, "reach_100");
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_vec", vec, 0);
        chk("mid_rst_cnt1", cnt1, 0);
        press_btn(1, 0);
        wait_sig(2, 8'd1, 1200, "fresh_done");
        chk_counts("fresh");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_sweep_ctrl.md
# logic_sweep_ctrl

Sequencer for the board's combinational switch-logic function blocks. In MANUAL mode it drives the function input from the eight slide switches. In AUTO mode it sweeps the input vector through all 256 values at a fixed rate, samples the 3-bit function response on every step and counts the ones per output bit. It sits between the board I/O (switches, buttons) and the logic block under test; the top level maps its outputs to LEDs.

## Interface
Parameters:
- TICK_DIV, 10_000_000: clk cycles per sweep step; minimum 2.
- DB_CYCLES, 1_000_000: cycles a button must be stable before a press is accepted; minimum 1.

Ports:
- clk, in, 1: board clock; the block runs on this single clock.
- rst, in, 1: synchronous, active-high reset.
- sw, in, 8: slide switches, used as the vector source in MANUAL.
- btn_mode, in, 1: raw mode button, asynchronous and bouncy.
- btn_step, in, 1: raw single-step button, asynchronous and bouncy.
- f_in, in, 3: combinational response of the function block to vec.
- vec, out, 8: registered input vector to the function block.
- state, out, 2: current state; MANUAL=0, RUN=1, PAUSE=2, DONE=3.
- cnt0, cnt1, cnt2, out, 9 each: ones-count of f_in[0], f_in[1] and f_in[2] over the sweep.
- done, out, 1: one-cycle pulse when a sweep completes.

## Operation
- Buttons:
  - Each button passes through a 2-flop synchronizer and then a debouncer.
  - The debouncer emits a one-cycle press pulse on the debounced rising edge only.
  - Holding a button produces exactly one pulse.
- MANUAL:
  - vec <= sw every cycle.
  - mode press -> RUN, with vec <= 0, all counts <= 0, tick counter <= 0.
  - step press is ignored.
- RUN:
  - The tick counter counts 0..TICK_DIV-1; a tick fires when it wraps.
  - On a tick, each cntk += f_in[k], then vec increments.
  - On a tick with vec==255: counts accumulate, vec holds 255, state -> DONE, done pulses.
  - mode press -> PAUSE; the tick counter freezes at its current value.
- PAUSE:
  - step press performs one step with the same accumulate/increment/last-vector rules as a tick.
  - mode press -> RUN; the tick counter resumes from its frozen value.
- DONE:
  - vec and the counts hold.
  - mode press -> MANUAL; counts stay visible until the next sweep starts.
  - step press is ignored.
- Simultaneous mode and step pulses in the same cycle: mode wins and step is dropped.
- A tick in the same cycle as a mode press in RUN: the step executes and the state change applies as well. If that step is the last vector, DONE wins.
- Count arithmetic:
  - Counters are 9 bits, unsigned. The maximum value is 256, so no overflow is possible.
  - Counts are cleared only on entry to RUN from MANUAL, or by rst.
- Reset, including mid-sweep:
  - state=MANUAL, vec=0, cnt0..cnt2=0, done=0, tick counter=0.
  - Debouncer counters and stable levels reset to 0 (released).
  - No partial sweep state survives reset.

## Timing
- All outputs are registered.
- MANUAL latency: sw to vec is 1 cycle. The synchronizer is not applied to sw; the switches are treated as quasi-static.
- Button to press pulse: 2 synchronizer cycles plus DB_CYCLES stable cycles plus 1 cycle.
- f_in is sampled on the tick cycle; vec has been stable for at least TICK_DIV-1 cycles by then.
- First tick after entering RUN occurs TICK_DIV cycles after the mode pulse.
- Full uninterrupted sweep: the last tick occurs 256*TICK_DIV cycles after the mode pulse.
- done is asserted on the cycle the state register becomes DONE, for one cycle.

## Structure
- Shared package holds:
  - the state enum: MANUAL, RUN, PAUSE, DONE, 2 bits;
  - the constants VEC_W=8, FN_W=3, CNT_W=9.
- One sub-module, btn_debounce, parameterized by DB_CYCLES:
  - ports clk, rst, btn_raw, press;
  - contains the synchronizer, stable counter and edge detector;
  - instantiated twice.
- Tick divider, FSM, vec register and counters live in logic_sweep_ctrl.

## Test plan
Bench settings: TICK_DIV=4, DB_CYCLES=3. Bench function model: f_in = {vec==8'hFF, vec[1]&vec[2]&vec[3], vec[0]^vec[1]}.
- Reset and manual: after rst, outputs read state=0, vec=0, counts 0, done 0. Then sw=8'hA5 -> vec=8'hA5 one cycle later; step press -> no state change.
- Full sweep: mode press -> state=1. 1024 cycles later, done pulses once and state=3 with cnt0=128, cnt1=32, cnt2=1, vec=255.
- Pause and step: mode press in RUN at vec=10 -> state=2, vec holds 10 for more than 100 cycles. 5 step presses -> vec=15. mode press -> RUN resumes; the sweep completes with the same counts as an uninterrupted run.
- Bounce: btn_mode toggling every cycle for 10 cycles, then held high -> exactly one press pulse; a 2-cycle glitch -> no pulse.
- Simultaneous presses: mode and step pulse on the same cycle in PAUSE -> state=RUN and vec unchanged by the step.
- Reset mid-sweep: rst at vec=100 -> next cycle shows state=0, vec=0, counts 0. A fresh sweep then yields 128/32/1.
